// File: rtl/mult_div_iterativo.sv
// rtl/mult_div_iterativo.sv - iterative radix-2 multiply/divide unit with HI/LO result registers
//
// Executes MULT, MULTU, DIV and DIVU one bit per clock. Signed operations work on
// magnitudes and fix the sign in a final FIX cycle.
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     synchronous active-low reset
//   i_start     request, sampled only while idle
//   i_op        00=MULT 01=MULTU 10=DIV 11=DIVU, captured with i_start
//   i_dato1     operand A (multiplicand / dividend)
//   i_dato2     operand B (multiplier / divisor)
//   o_hi        MULT: upper product, DIV: remainder
//   o_lo        MULT: lower product, DIV: quotient
//   o_busy      high while an operation is in progress
//   o_listo     one-cycle pulse when o_hi/o_lo have just been written
//   o_div_cero  divide-by-zero flag, updated with every o_listo
module mult_div_iterativo #(
   parameter int N     = 32,
   parameter int CNT_W = 5
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic [1:0]   i_op,
   input  logic [N-1:0] i_dato1,
   input  logic [N-1:0] i_dato2,
   output logic [N-1:0] o_hi,
   output logic [N-1:0] o_lo,
   output logic         o_busy,
   output logic         o_listo,
   output logic         o_div_cero
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2*N-1:0]   r_acc;     // MULT: {partial product, multiplier}; DIV: {remainder, quotient}
   logic [N-1:0]     r_a;       // multiplicand or divisor magnitude
   logic             r_is_div;
   logic             r_neg_q;   // product / quotient must be negated
   logic             r_neg_r;   // remainder must be negated (dividend was negative)
   logic             r_dz;
   logic [N-1:0]     r_hi;
   logic [N-1:0]     r_lo;
   logic             r_listo;
   logic             r_div_cero;

   logic             w_signed;
   logic             w_is_div;
   logic             w_a_neg;
   logic             w_b_neg;
   logic [N-1:0]     w_abs_a;
   logic [N-1:0]     w_abs_b;
   logic [N-1:0]     w_add;
   logic [N:0]       w_sum;
   logic [2*N-1:0]   w_mul_next;
   logic [N:0]       w_rem_sh;
   logic             w_ge;
   logic [N-1:0]     w_rem_sub;
   logic [2*N-1:0]   w_div_next;
   logic [2*N-1:0]   w_prod_neg;
   logic [N-1:0]     w_q_neg;
   logic [N-1:0]     w_r_neg;

   assign w_signed = ~i_op[0];
   assign w_is_div = i_op[1];
   assign w_a_neg  = w_signed & i_dato1[N-1];
   assign w_b_neg  = w_signed & i_dato2[N-1];
   // Magnitude of the most negative value wraps to itself, which is still correct as unsigned.
   assign w_abs_a  = w_a_neg ? (~i_dato1) + N'(1) : i_dato1;
   assign w_abs_b  = w_b_neg ? (~i_dato2) + N'(1) : i_dato2;

   // Shift-add: conditionally add multiplicand to the upper half, then shift right with carry.
   assign w_add      = r_acc[0] ? r_a : '0;
   assign w_sum      = {1'b0, r_acc[2*N-1:N]} + {1'b0, w_add};
   assign w_mul_next = {w_sum, r_acc[N-1:1]};

   // Restoring divide: shift next dividend bit into the remainder, subtract if it fits.
   // The shifted remainder is below 2*divisor, so the difference always fits in N bits.
   assign w_rem_sh   = {r_acc[2*N-1:N], r_acc[N-1]};
   assign w_ge       = w_rem_sh >= {1'b0, r_a};
   assign w_rem_sub  = w_rem_sh[N-1:0] - r_a;
   assign w_div_next = w_ge ? {w_rem_sub, r_acc[N-2:0], 1'b1}
                            : {w_rem_sh[N-1:0], r_acc[N-2:0], 1'b0};

   assign w_prod_neg = (~r_acc) + (2*N)'(1);
   assign w_q_neg    = (~r_acc[N-1:0]) + N'(1);
   assign w_r_neg    = (~r_acc[2*N-1:N]) + N'(1);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_a        <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_dz       <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_listo    <= 1'b0;
         r_div_cero <= 1'b0;
      end else begin
         r_listo <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cnt    <= '0;
                  r_is_div <= w_is_div;
                  if (w_is_div && (i_dato2 == '0)) begin
                     // Preload the divide-by-zero result so FIX passes it through unchanged.
                     r_acc   <= {i_dato1, {N{1'b1}}};
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                     r_dz    <= 1'b1;
                     r_state <= S_FIX;
                  end else begin
                     r_dz    <= 1'b0;
                     r_neg_q <= w_a_neg ^ w_b_neg;
                     r_neg_r <= w_a_neg;
                     if (w_is_div) begin
                        r_a   <= w_abs_b;
                        r_acc <= {{N{1'b0}}, w_abs_a};
                     end else begin
                        r_a   <= w_abs_a;
                        r_acc <= {{N{1'b0}}, w_abs_b};
                     end
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(N-1)) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (r_is_div) begin
                  r_hi <= r_neg_r ? w_r_neg : r_acc[2*N-1:N];
                  r_lo <= r_neg_q ? w_q_neg : r_acc[N-1:0];
               end else begin
                  {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_acc;
               end
               r_listo    <= 1'b1;
               r_div_cero <= r_dz;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_busy     = (r_state != S_IDLE);
   assign o_listo    = r_listo;
   assign o_div_cero = r_div_cero;

endmodule

// File: tb/tb_mult_div_iterativo.sv
// tb/tb_mult_div_iterativo.sv - self-checking bench for mult_div_iterativo
module tb_mult_div_iterativo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] dato1 = '0;
   logic [31:0] dato2 = '0;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        listo;
   logic        div_cero;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   mult_div_iterativo #(.N(32), .CNT_W(5)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_op       (op),
      .i_dato1    (dato1),
      .i_dato2    (dato2),
      .o_hi       (hi),
      .o_lo       (lo),
      .o_busy     (busy),
      .o_listo    (listo),
      .o_div_cero (div_cero)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Returns {div_cero, hi, lo} from plain 64-bit arithmetic.
   function automatic logic [64:0] ref_model(input logic [1:0] f_op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint    sa;
      longint    sb;
      longint    q;
      longint    r;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] res;
      logic        dz;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'b0, a};
      ub  = {32'b0, b};
      dz  = 1'b0;
      res = '0;
      if (f_op[1] && b == 32'd0) begin
         dz  = 1'b1;
         res = {a, 32'hFFFF_FFFF};
      end else begin
         case (f_op)
            2'd0: res = 64'(sa * sb);
            2'd1: res = ua * ub;
            2'd2: begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
            default: begin
               res = {32'(ua % ub), 32'(ua / ub)};
            end
         endcase
      end
      return {dz, res};
   endfunction

   task automatic run_op(input logic [1:0] t_op, input logic [31:0] a, input logic [31:0] b,
                         input bit mid_start);
      logic [64:0] e;
      int n;
      int lat;
      e   = ref_model(t_op, a, b);
      lat = e[64] ? 1 : 33;
      @(negedge clk);
      start = 1'b1;
      op    = t_op;
      dato1 = a;
      dato2 = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      dato1 = $urandom;
      dato2 = $urandom;
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (listo) break;
         check("busy_during_op", busy, 1);
         start = (mid_start && n == 5) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      check("latency", n, lat);
      check("busy_in_listo", busy, 0);
      check("hi", hi, e[63:32]);
      check("lo", lo, e[31:0]);
      check("div_cero", div_cero, e[64]);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] ra;
      logic [31:0] rb;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", busy, 0);
      check("rst_listo", listo, 0);
      check("rst_div_cero", div_cero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_max_hi", hi, 32'hFFFF_FFFE);
      run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
      check("mult_neg_lo", lo, 32'hFFFF_FFEB);
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_neg_q", lo, 32'hFFFF_FFFD);
      run_op(2'd3, 32'd100, 32'd7, 1'b0);
      check("divu_b2b_r", hi, 32'd2);
      run_op(2'd2, 32'd5, 32'd0, 1'b0);
      check("div0_hi", hi, 32'd5);
      run_op(2'd1, 32'd2, 32'd3, 1'b0);
      check("clear_dz", div_cero, 0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      check("div_ovf_q", lo, 32'h8000_0000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("single_listo", listo, 0);
      end

      for (int i = 0; i < 20; i++) begin
         r_op = 2'($urandom_range(0, 3));
         ra   = $urandom;
         rb   = $urandom;
         if ($urandom_range(0, 5) == 0) rb = 32'd0;
         else if ($urandom_range(0, 2) == 0) rb = 32'($signed($urandom_range(0, 40)) - 20);
         run_op(r_op, ra, rb, 1'b0);
      end

      // Reset in the middle of a multiply aborts it.
      @(negedge clk);
      start = 1'b1;
      op    = 2'd0;
      dato1 = 32'd9;
      dato2 = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("abort_busy", busy, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      check("abort_listo", listo, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         check("abort_no_listo", listo, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
